// File: rtl/bispec_triple_sched.sv
// ============================================================================
// bispec_triple_sched: two-pass sequencer computing Y = A*B*conj(C) on one
// shared Q(FRAC_W) complex multiplier. Optional clamp: BISPEC_TRIPLE_SAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bispec_triple_sched #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 14,
   parameter int TAG_W  = 16,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] ar,
   input  logic [DATA_W-1:0] ai,
   input  logic [DATA_W-1:0] br,
   input  logic [DATA_W-1:0] bi,
   input  logic [DATA_W-1:0] cr,
   input  logic [DATA_W-1:0] ci,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] yr,
   output logic [DATA_W-1:0] yi,
   output logic [TAG_W-1:0]  out_tag,
   output logic [CNT_W-1:0]  tri_cnt
);

   localparam int PROD_W = 2*DATA_W + 1;
   localparam logic [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL1 = 2'd1,
      MUL2 = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] ar_q, ai_q, br_q, bi_q, cr_q, ci_q;
   logic [DATA_W-1:0] ar_d, ai_d, br_d, bi_d, cr_d, ci_d;
   logic [DATA_W-1:0] pr_q, pi_q, pr_d, pi_d;
   logic [DATA_W-1:0] yr_q, yi_q, yr_d, yi_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [DATA_W-1:0] nci;
   logic [DATA_W-1:0] mxr, mxi, myr, myi;
   logic signed [PROD_W-1:0] xr_e, xi_e, yr_e, yi_e;
   logic signed [PROD_W-1:0] re_full, im_full;
   logic [DATA_W-1:0] mul_r, mul_i;

`ifdef BISPEC_TRIPLE_SAT_EN
   localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   logic signed [PROD_W-1:0] re_sh, im_sh;

   assign nci   = (ci_q == DMIN) ? ~DMIN : -ci_q;
   assign re_sh = re_full >>> FRAC_W;
   assign im_sh = im_full >>> FRAC_W;

   always_comb begin
      mul_r = re_sh[DATA_W-1:0];
      mul_i = im_sh[DATA_W-1:0];
      if (re_sh > SAT_MAX)      mul_r = SAT_MAX[DATA_W-1:0];
      else if (re_sh < SAT_MIN) mul_r = SAT_MIN[DATA_W-1:0];
      if (im_sh > SAT_MAX)      mul_i = SAT_MAX[DATA_W-1:0];
      else if (im_sh < SAT_MIN) mul_i = SAT_MIN[DATA_W-1:0];
   end
`else
   logic unused_prod_bits;

   // Floor shift then wrap is just a bit-slice of the full-width sum.
   assign nci   = -ci_q;
   assign mul_r = re_full[FRAC_W +: DATA_W];
   assign mul_i = im_full[FRAC_W +: DATA_W];
   assign unused_prod_bits = ^{re_full[FRAC_W-1:0], re_full[PROD_W-1:FRAC_W+DATA_W],
                               im_full[FRAC_W-1:0], im_full[PROD_W-1:FRAC_W+DATA_W]};
`endif

   always_comb begin
      mxr = ar_q;
      mxi = ai_q;
      myr = br_q;
      myi = bi_q;
      if (state_q == MUL2) begin
         mxr = pr_q;
         mxi = pi_q;
         myr = cr_q;
         myi = nci;
      end
   end

   assign xr_e = {{(PROD_W-DATA_W){mxr[DATA_W-1]}}, mxr};
   assign xi_e = {{(PROD_W-DATA_W){mxi[DATA_W-1]}}, mxi};
   assign yr_e = {{(PROD_W-DATA_W){myr[DATA_W-1]}}, myr};
   assign yi_e = {{(PROD_W-DATA_W){myi[DATA_W-1]}}, myi};

   assign re_full = xr_e*yr_e - xi_e*yi_e;
   assign im_full = xr_e*yi_e + xi_e*yr_e;

   always_comb begin
      state_d = state_q;
      ar_d = ar_q; ai_d = ai_q;
      br_d = br_q; bi_d = bi_q;
      cr_d = cr_q; ci_d = ci_q;
      pr_d = pr_q; pi_d = pi_q;
      yr_d = yr_q; yi_d = yi_q;
      tag_d = tag_q;
      cnt_d = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               ar_d = ar; ai_d = ai;
               br_d = br; bi_d = bi;
               cr_d = cr; ci_d = ci;
               tag_d   = in_tag;
               state_d = MUL1;
            end
         end
         MUL1: begin
            pr_d    = mul_r;
            pi_d    = mul_i;
            state_d = MUL2;
         end
         MUL2: begin
            yr_d    = mul_r;
            yi_d    = mul_i;
            state_d = OUT;
         end
         OUT: begin
            if (out_ready) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ar_q <= '0; ai_q <= '0;
         br_q <= '0; bi_q <= '0;
         cr_q <= '0; ci_q <= '0;
         pr_q <= '0; pi_q <= '0;
         yr_q <= '0; yi_q <= '0;
         tag_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         ar_q <= ar_d; ai_q <= ai_d;
         br_q <= br_d; bi_q <= bi_d;
         cr_q <= cr_d; ci_q <= ci_d;
         pr_q <= pr_d; pi_q <= pi_d;
         yr_q <= yr_d; yi_q <= yi_d;
         tag_q <= tag_d;
         cnt_q <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == OUT);
   assign yr        = yr_q;
   assign yi        = yi_q;
   assign out_tag   = tag_q;
   assign tri_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bispec_triple_sched.sv
// ============================================================================
// tb_bispec_triple_sched: directed self-checking bench for bispec_triple_sched.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bispec_triple_sched;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid, in_ready;
   logic signed [15:0] ar, ai, br, bi, cr, ci;
   logic [15:0]        in_tag;
   logic               out_valid, out_ready;
   logic signed [15:0] yr, yi;
   logic [15:0]        out_tag;
   logic [31:0]        tri_cnt;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   bispec_triple_sched #(
      .DATA_W(16), .FRAC_W(14), .TAG_W(16), .CNT_W(32)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .ar(ar), .ai(ai), .br(br), .bi(bi), .cr(cr), .ci(ci),
      .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .yr(yr), .yi(yi), .out_tag(out_tag), .tri_cnt(tri_cnt)
   );

`ifdef BISPEC_TRIPLE_SAT_EN
   localparam int EXP_T3_YR  = 32767;
   localparam int EXP_CNJ_YI = 32767;
`else
   localparam int EXP_T3_YR  = 0;
   localparam int EXP_CNJ_YI = -32768;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input string nm, input int a_r, a_i, b_r, b_i, c_r, c_i,
                       input logic [15:0] tg);
      int n;
      ar = 16'(a_r); ai = 16'(a_i);
      br = 16'(b_r); bi = 16'(b_i);
      cr = 16'(c_r); ci = 16'(c_i);
      in_tag   = tg;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk({nm, "_in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      // operands must be ignored once latched
      ar = 16'($urandom); ai = 16'($urandom);
      br = 16'($urandom); bi = 16'($urandom);
      cr = 16'($urandom); ci = 16'($urandom);
      in_tag = 16'($urandom);
   endtask

   task automatic wait_out(input string nm);
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({nm, "_latency"}, lat, 2);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic triple(input string nm, input int a_r, a_i, b_r, b_i, c_r, c_i,
                         input logic [15:0] tg, input int eyr, input int eyi);
      send(nm, a_r, a_i, b_r, b_i, c_r, c_i, tg);
      wait_out(nm);
      chk({nm, "_yr"}, yr, eyr);
      chk({nm, "_yi"}, yi, eyi);
      chk({nm, "_tag"}, out_tag, tg);
      release_out();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_cyc[5];
      int nacc, nout, cyc;
      logic acc_hs;

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0;
      ar = '0; ai = '0; br = '0; bi = '0; cr = '0; ci = '0; in_tag = '0;
      #3;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_yr", yr, 0);
      chk("rst_yi", yi, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_tri_cnt", tri_cnt, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("idle_in_ready", in_ready, 1);

      // A=B=C=(0.5,0.5): P=(0,0.5), Y=(0.25,0.25)
      triple("t2", 8192, 8192, 8192, 8192, 8192, 8192, 16'h0202, 4096, 4096);
      chk("t2_cnt", tri_cnt, 1);

      triple("t1", 16384, 0, 0, 16384, 16384, 0, 16'h0102, 0, 16384);
      // -1 LSB * 1.0 floors to -1 rather than 0
      triple("flr", -1, 0, 1, 0, 16384, 0, 16'h0303, -1, 0);
      // conj of Ci = -32768 wraps (or clamps)
      triple("cnj", 16384, 0, 16384, 0, 0, -32768, 16'h0404, 0, EXP_CNJ_YI);
      triple("t3", -32768, 0, -32768, 0, 16384, 0, 16'h0505, EXP_T3_YR, 0);
      chk("t3_cnt", tri_cnt, 5);

      // stalled output
      send("t4", 16384, 0, 0, 16384, 16384, 0, 16'h0606);
      wait_out("t4");
      in_valid = 1'b1;
      ar = 16'sd100; ai = -16'sd7; br = 16'sd3; bi = 16'sd9; cr = 16'sd1; ci = 16'sd2;
      in_tag = 16'h0707;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_hold_yi", yi, 16384);
         chk("t4_hold_tag", out_tag, 16'h0606);
         chk("t4_hold_in_ready", in_ready, 0);
      end
      chk("t4_hold_yr", yr, 0);
      chk("t4_hold_valid", out_valid, 1);
      in_valid = 1'b0;
      release_out();
      chk("t4_cnt", tri_cnt, 6);
      tick(); tick(); tick();
      chk("t4_cnt_once", tri_cnt, 6);
      chk("t4_valid_low", out_valid, 0);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("rst2_cnt", tri_cnt, 0);

      // back-to-back stream of 5 triples
      ar = 16'sd8192; ai = 16'sd8192; br = 16'sd8192; bi = 16'sd8192;
      cr = 16'sd8192; ci = 16'sd8192;
      in_tag = 16'h0500;
      in_valid = 1'b1;
      out_ready = 1'b1;
      nacc = 0; nout = 0; cyc = 0;
      while ((nacc < 5 || nout < 5) && cyc < 60) begin
         @(negedge clk);
         acc_hs = in_valid && in_ready;
         if (acc_hs) acc_cyc[nacc] = cyc;
         if (out_valid && out_ready) begin
            chk("t5_tag", out_tag, 16'h0500 + 16'(nout));
            chk("t5_yr", yr, 4096);
            nout++;
         end
         tick();
         cyc++;
         if (acc_hs) begin
            nacc++;
            in_tag = 16'h0500 + 16'(nacc);
            if (nacc == 5) in_valid = 1'b0;
         end
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("t5_nacc", nacc, 5);
      chk("t5_nout", nout, 5);
      for (int i = 1; i < 5; i++) chk("t5_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
      chk("t5_cnt", tri_cnt, 5);

      // async reset during MUL2
      send("t6", 8192, 8192, 8192, 8192, 8192, 8192, 16'h0808);
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("t6_out_valid", out_valid, 0);
      chk("t6_yr", yr, 0);
      chk("t6_yi", yi, 0);
      chk("t6_cnt", tri_cnt, 0);
      chk("t6_in_ready", in_ready, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("t6_post_ready", in_ready, 1);
      chk("t6_post_valid", out_valid, 0);
      triple("t6b", 16384, 0, 0, 16384, 16384, 0, 16'h0909, 0, 16384);
      chk("t6b_cnt", tri_cnt, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
